dm_pipe: RTL and testbench



---
 rtl/dm_pkg.sv | 39 +++
 rtl/dm_lane_fmt.sv | 49 ++++
 rtl/dm_pipe.sv | 110 +++++++++++
 tb/tb_dm_pipe.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared definitions for the dm_pipe data-memory block: op codes, lane-enable
// constants, the pipeline stage record and the misalignment rule.
package dm_pkg;

  localparam int DM_OP_W = 3;
  localparam int DM_BE_W = 4;

  // Codes 5..7 are not named and fall through to word behaviour
  typedef enum logic [DM_OP_W-1:0] {
    OP_W  = 3'd0,
    OP_H  = 3'd1,
    OP_HU = 3'd2,
    OP_B  = 3'd3,
    OP_BU = 3'd4
  } dm_op_e;

  localparam logic [DM_BE_W-1:0] BE_WORD    = 4'b1111;
  localparam logic [DM_BE_W-1:0] BE_HALF_LO = 4'b0011;
  localparam logic [DM_BE_W-1:0] BE_HALF_HI = 4'b1100;
  localparam logic [DM_BE_W-1:0] BE_BYTE0   = 4'b0001;

  typedef struct packed {
    logic               vld;
    logic               err;
    logic [DM_OP_W-1:0] op;
    logic [1:0]         lo;
    logic [31:0]        word;
  } dm_stage_t;

  function automatic logic dm_misaligned(input logic [DM_OP_W-1:0] op,
                                         input logic [1:0] lo);
    case (op)
      OP_H, OP_HU: return lo[0];
      OP_B, OP_BU: return 1'b0;
      default:     return lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/dm_lane_fmt.sv
// Byte-lane formatter: store-side enables/replication and load-side lane
// extraction with sign or zero extension, all keyed on op and addr[1:0].
module dm_lane_fmt
  import dm_pkg::*;
(
  input  logic [DM_OP_W-1:0] op,
  input  logic [1:0]         lo,
  input  logic [31:0]        wdata,
  input  logic [31:0]        word,
  output logic [DM_BE_W-1:0] be,
  output logic [31:0]        sdata,
  output logic [31:0]        ldata
);

  logic [15:0] half;
  logic [7:0]  byt;

  always_comb begin
    be    = BE_WORD;
    sdata = wdata;
    ldata = word;
    half  = lo[1] ? word[31:16] : word[15:0];
    byt   = word[{lo, 3'b000} +: 8];
    case (op)
      OP_H: begin
        be    = lo[1] ? BE_HALF_HI : BE_HALF_LO;
        sdata = {2{wdata[15:0]}};
        ldata = {{16{half[15]}}, half};
      end
      OP_HU: begin
        be    = lo[1] ? BE_HALF_HI : BE_HALF_LO;
        sdata = {2{wdata[15:0]}};
        ldata = {16'h0000, half};
      end
      OP_B: begin
        be    = BE_BYTE0 << lo;
        sdata = {4{wdata[7:0]}};
        ldata = {{24{byt[7]}}, byt};
      end
      OP_BU: begin
        be    = BE_BYTE0 << lo;
        sdata = {4{wdata[7:0]}};
        ldata = {24'h000000, byt};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dm_pipe.sv
// Pipelined data memory for the MEM stage with READ_LAT-deep load pipeline and
// full back-pressure. Define DM_MISALIGN_EXC_EN to report misaligned accesses.
module dm_pipe
  import dm_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int READ_LAT   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [DM_OP_W-1:0] req_op,
  input  logic [31:0]        req_addr,
  input  logic [31:0]        req_wdata,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [31:0]        rsp_data,
  output logic               rsp_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [31:0]           mem [DEPTH];
  dm_stage_t             pipe [READ_LAT];
  dm_stage_t             entry;
  dm_stage_t             out;
  logic [DEPTH_LOG2-1:0] idx;
  logic [31:0]           rd_word;
  logic                  stall;
  logic                  accept;
  logic                  bad;
  logic [DM_BE_W-1:0]    st_be;
  logic [31:0]           st_data;
  logic [31:0]           ld_data;
  logic [31:0]           st_ext_unused;
  logic [DM_BE_W-1:0]    ld_be_unused;
  logic                  unused_addr;

  assign unused_addr = ^{req_addr[31:DEPTH_LOG2+2]};

  assign out       = pipe[READ_LAT-1];
  assign stall     = out.vld && !rsp_ready;
  assign req_ready = !rst && !stall;
  assign accept    = req_valid && req_ready;
  assign idx       = req_addr[DEPTH_LOG2+1:2];
  assign rd_word   = mem[idx];

`ifdef DM_MISALIGN_EXC_EN
  assign bad = dm_misaligned(req_op, req_addr[1:0]);
`else
  assign bad = 1'b0;
`endif

  dm_lane_fmt u_st_fmt (
    .op    (req_op),
    .lo    (req_addr[1:0]),
    .wdata (req_wdata),
    .word  ('0),
    .be    (st_be),
    .sdata (st_data),
    .ldata (st_ext_unused)
  );

  always_ff @(posedge clk) begin
    if (accept && req_we && !bad) begin
      for (int unsigned b = 0; b < DM_BE_W; b++) begin
        if (st_be[b]) mem[idx][8*b +: 8] <= st_data[8*b +: 8];
      end
    end
  end

  // Loads capture the whole word at accept; misaligned stores also enter the
  // pipe so their error response keeps normal latency and order.
  always_comb begin
    entry = '0;
    if (accept && (!req_we || bad)) begin
      entry.vld  = 1'b1;
      entry.err  = bad;
      entry.op   = req_op;
      entry.lo   = req_addr[1:0];
      entry.word = bad ? '0 : rd_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < READ_LAT; i++) pipe[i] <= '0;
    end else if (!stall) begin
      pipe[0] <= entry;
      for (int unsigned i = 1; i < READ_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  dm_lane_fmt u_ld_fmt (
    .op    (out.op),
    .lo    (out.lo),
    .wdata ('0),
    .word  (out.word),
    .be    (ld_be_unused),
    .sdata (),
    .ldata (ld_data)
  );

  assign rsp_valid = out.vld;
  assign rsp_err   = out.err;
  assign rsp_data  = out.err ? '0 : ld_data;

endmodule

// File: tb/tb_dm_pipe.sv
// Scoreboard bench for dm_pipe: byte-addressed reference memory, directed
// cases, back-pressure, mid-flight reset and randomized traffic.
module tb_dm_pipe;

  localparam int LAT = 3;
  localparam int DL2 = 6;
  localparam int NBYTES = 4 << DL2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_op = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data;
  logic        rsp_err;

  dm_pipe #(.DEPTH_LOG2(DL2), .READ_LAT(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          t_acc;
    bit          chk_lat;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  mbytes [NBYTES];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          mode = 0;   // 0: ready high, 1: random ready, 2: one 3-cycle stall
  int          stall_cycles = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic int size_of(input logic [2:0] op);
    if (op == 3'd3 || op == 3'd4) return 1;
    if (op == 3'd1 || op == 3'd2) return 2;
    return 4;
  endfunction

  function automatic bit model_mis(input logic [2:0] op, input logic [31:0] addr);
`ifdef DM_MISALIGN_EXC_EN
    return (addr % size_of(op)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  // Reference behaviour at accept time: stores write bytes immediately, loads
  // (and error responses) push the expected response.
  function automatic void model_accept(input bit we, input logic [2:0] op,
                                       input logic [31:0] addr, input logic [31:0] wd);
    int sz = size_of(op);
    int base = int'(addr) - (int'(addr) % sz);
    logic [31:0] v = '0;
    exp_t e;
    e.t_acc = cyc;
    e.chk_lat = (mode == 0);
    if (model_mis(op, addr)) begin
      e.data = '0; e.err = 1'b1; q.push_back(e);
      return;
    end
    if (we) begin
      for (int k = 0; k < sz; k++) mbytes[base+k] = 8'(wd >> (8*k));
      return;
    end
    for (int k = 0; k < sz; k++) v = v | (32'(mbytes[base+k]) << (8*k));
    if (op == 3'd1 && v[15]) v = v | 32'hFFFF0000;
    if (op == 3'd3 && v[7])  v = v | 32'hFFFFFF00;
    e.data = v; e.err = 1'b0; q.push_back(e);
  endfunction

  task automatic issue(input bit we, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wd);
    int n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_op = op; req_addr = addr; req_wdata = wd;
    #1;
    while (!req_ready) begin
      n++;
      if (n > 200) begin
        $display("FAIL req_accept_timeout: got req_ready=0 expected 1 within 200 cycles");
        $fatal(1, "request never accepted");
      end
      @(negedge clk); #1;
    end
    model_accept(we, op, addr, wd);
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 400) begin @(negedge clk); n++; end
    chk("drain_empty", q.size(), 0);
  endtask

  // rsp_ready owner
  initial begin
    int stall_cnt = 0;
    bit done = 1'b0;
    forever begin
      @(negedge clk);
      case (mode)
        1: rsp_ready = ($urandom_range(0, 3) != 0);
        2: begin
          if (stall_cnt > 0) begin rsp_ready = 1'b0; stall_cnt--; end
          else rsp_ready = 1'b1;
        end
        default: begin rsp_ready = 1'b1; done = 1'b0; end
      endcase
      #3;
      if (mode == 2 && !done && rsp_valid && rsp_ready) begin
        stall_cnt = 3; done = 1'b1;
      end
    end
  end

  // Monitor: compare every presented response against the scoreboard head
  initial begin
    exp_t e;
    bit fresh = 1'b1;
    forever begin
      @(negedge clk); #2;
      if (rst) begin fresh = 1'b1; continue; end
      if (!rsp_valid) begin fresh = 1'b1; continue; end
      if (q.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
        continue;
      end
      e = q[0];
      chk("rsp_data", rsp_data, e.data);
      chk("rsp_err", 32'(rsp_err), 32'(e.err));
      if (fresh && e.chk_lat) chk("latency", cyc - e.t_acc, LAT);
      if (!rsp_ready) begin
        stall_cycles++;
        chk("req_ready_stall", 32'(req_ready), 32'd0);
        fresh = 1'b0;
      end else begin
        void'(q.pop_front());
        fresh = 1'b1;
      end
    end
  end

  initial begin
    for (int i = 0; i < NBYTES; i++) mbytes[i] = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk); rst = 1'b0;

    // Directed data-path cases, ready held high
    issue(1, 3'd0, 32'h10, 32'h11223344);
    issue(0, 3'd0, 32'h10, '0);
    issue(1, 3'd3, 32'h13, 32'h00000080);
    issue(0, 3'd3, 32'h13, '0);
    issue(0, 3'd4, 32'h13, '0);
    issue(0, 3'd0, 32'h10, '0);
    issue(1, 3'd1, 32'h22, 32'h0000BEEF);
    issue(0, 3'd1, 32'h22, '0);
    issue(0, 3'd2, 32'h20, '0);
    issue(0, 3'd0, 32'h12, '0);
    issue(1, 3'd2, 32'h31, 32'h0000A55A);
    issue(0, 3'd7, 32'h30, '0);
    issue(0, 3'd2, 32'h31, '0);
    idle(2);
    drain();

    // Back-pressure: four back-to-back loads, 3-cycle stall after first response
    mode = 2;
    issue(0, 3'd0, 32'h10, '0);
    issue(0, 3'd0, 32'h20, '0);
    issue(0, 3'd3, 32'h13, '0);
    issue(0, 3'd2, 32'h22, '0);
    idle(2);
    drain();
    mode = 0;
    chk("stall_seen", 32'(stall_cycles >= 3), 32'd1);

    // Reset with two loads in flight; the preceding store must persist
    issue(1, 3'd0, 32'h40, 32'hCAFEF00D);
    issue(0, 3'd0, 32'h10, '0);
    issue(0, 3'd0, 32'h14, '0);
    @(negedge clk);
    req_valid = 1'b0; rst = 1'b1;
    q.delete();
    @(posedge clk); #1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd0);
    chk("midrst_rsp_data", rsp_data, 32'd0);
    @(negedge clk); rst = 1'b0;
    idle(8);
    issue(0, 3'd0, 32'h40, '0);
    idle(2);
    drain();

    // Randomized traffic with random back-pressure
    mode = 1;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            32'($urandom_range(0, NBYTES - 1)), $urandom);
    end
    idle(2);
    drain();
    mode = 0;
    idle(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
